// File: rtl/response_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : response_uart_tx
//  Purpose  : Reader/transmitter end of the PUF response buffer. It waits for
//             the buffer to raise ready_to_read and captures the response
//             byte. It then sends that byte to the host PC as one UART frame
//             (8N1, LSB first). After the frame it holds tx_done until the
//             host acknowledge (computer_ack_reset) clears the block.
//             Exactly one frame is sent per challenge/response cycle.
//  Options  : `define RESP_PARITY_EN to add an even-parity bit (8E1 frame).
//  Ports    : clock              - system clock, rising edge
//             computer_ack_reset - asynchronous active-high reset / host ack
//             ready_to_read      - buffer holds 8 response bits (sync)
//             data_in[7:0]       - response byte from buffer
//             tx                 - UART serial line, idle high
//             busy               - frame in progress (START..STOP)
//             tx_done            - frame complete, held until reset
//  Revision : 1.0 - initial release
// ============================================================================
module response_uart_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clock,
   input  logic       computer_ack_reset,
   input  logic       ready_to_read,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

   logic [2:0]       state;
   logic [CNT_W-1:0] baud_count;
   logic [2:0]       bit_index;
   logic [7:0]       shift_reg;
   logic             rtr_q;
   logic             start;
   logic             bit_tick;

   // Edge-triggered start: a level held high after the frame cannot restart it.
   assign start    = ready_to_read & ~rtr_q;
   assign bit_tick = (baud_count == CNT_LAST);

   always_ff @(posedge clock or posedge computer_ack_reset) begin
      if (computer_ack_reset) begin
         rtr_q <= 1'b0;
      end else begin
         rtr_q <= ready_to_read;
      end
   end

   // The baud counter runs only while a bit is on the line. It wraps at the
   // end of each bit, so every bit lasts exactly CLKS_PER_BIT cycles.
   always_ff @(posedge clock or posedge computer_ack_reset) begin
      if (computer_ack_reset) begin
         baud_count <= '0;
      end else if (state == IDLE || state == DONE || bit_tick) begin
         baud_count <= '0;
      end else begin
         baud_count <= baud_count + CNT_W'(1);
      end
   end

`ifdef RESP_PARITY_EN
   logic parity_bit;

   // The shift register is consumed during DATA, so parity is taken at capture.
   always_ff @(posedge clock or posedge computer_ack_reset) begin
      if (computer_ack_reset) begin
         parity_bit <= 1'b0;
      end else if (state == IDLE && start) begin
         parity_bit <= ^data_in;
      end
   end
`endif

   always_ff @(posedge clock or posedge computer_ack_reset) begin
      if (computer_ack_reset) begin
         state     <= IDLE;
         tx        <= 1'b1;
         busy      <= 1'b0;
         tx_done   <= 1'b0;
         bit_index <= 3'd0;
         shift_reg <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               tx   <= 1'b1;
               busy <= 1'b0;
               if (start) begin
                  shift_reg <= data_in;
                  tx        <= 1'b0;
                  busy      <= 1'b1;
                  state     <= START;
               end
            end
            START: begin
               if (bit_tick) begin
                  tx        <= shift_reg[0];
                  bit_index <= 3'd0;
                  state     <= DATA;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  if (bit_index != 3'd7) begin
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     tx        <= shift_reg[1];
                     bit_index <= bit_index + 3'd1;
                  end else begin
`ifdef RESP_PARITY_EN
                     tx    <= parity_bit;
                     state <= PARITY;
`else
                     tx    <= 1'b1;
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef RESP_PARITY_EN
            PARITY: begin
               if (bit_tick) begin
                  tx    <= 1'b1;
                  state <= STOP;
               end
            end
`endif
            STOP: begin
               if (bit_tick) begin
                  busy    <= 1'b0;
                  tx_done <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               // Terminal until the host acknowledges via reset.
               tx      <= 1'b1;
               busy    <= 1'b0;
               tx_done <= 1'b1;
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_response_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_response_uart_tx
//  Purpose  : Self-checking bench for response_uart_tx (CLKS_PER_BIT = 4).
//             The expected line level at each bit centre is derived from the
//             UART frame format of the byte being sent.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_response_uart_tx;

   localparam int N = 4;
`ifdef RESP_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       clock = 1'b0;
   logic       computer_ack_reset = 1'b0;
   logic       ready_to_read = 1'b0;
   logic [7:0] data_in = 8'd0;
   logic       tx;
   logic       busy;
   logic       tx_done;

   int tests = 0;
   int fails = 0;

   response_uart_tx #(.CLKS_PER_BIT(N)) dut (
      .clock              (clock),
      .computer_ack_reset (computer_ack_reset),
      .ready_to_read      (ready_to_read),
      .data_in            (data_in),
      .tx                 (tx),
      .busy               (busy),
      .tx_done            (tx_done)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Line level of frame bit k: start, 8 data bits LSB first, [parity], stop.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef RESP_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic ack_reset();
      @(negedge clock);
      computer_ack_reset = 1'b1;
      ready_to_read      = 1'b0;
      #1;
      check("ack_state", {31'd0, tx, busy, tx_done} , 32'b100);
      @(negedge clock);
      computer_ack_reset = 1'b0;
   endtask

   // Sends one frame and checks it bit by bit. new_data is driven onto data_in
   // mid-frame; drop_rtr releases ready_to_read mid-frame.
   task automatic send_frame(input logic [7:0] b, input logic [7:0] new_data, input bit drop_rtr);
      logic [7:0] decoded;
      int         bad_hold;
      decoded = 8'd0;
      @(negedge clock);
      check("idle", {29'd0, tx, busy, tx_done}, 32'b100);
      data_in       = b;
      ready_to_read = 1'b1;
      @(posedge clock);
      #1;
      check("start_fall", {31'd0, tx}, 32'd0);
      check("busy_on", {31'd0, busy}, 32'd1);
      @(negedge clock);
      for (int c = 0; c < NBITS * N; c++) begin
         if (c % N == N / 2) begin
            check("bit", {31'd0, tx}, {31'd0, frame_bit(b, c / N)});
            check("busy_frame", {30'd0, busy, tx_done}, 32'b10);
            if (c / N >= 1 && c / N <= 8) decoded[c/N-1] = tx;
         end
         if (c == NBITS * N - 1) check("done_early", {31'd0, tx_done}, 32'd0);
         if (c == 10) data_in = new_data;
         if (drop_rtr && c == 3 * N) ready_to_read = 1'b0;
         @(posedge clock);
         @(negedge clock);
      end
      check("done_state", {29'd0, tx, busy, tx_done}, 32'b101);
      check("byte", {24'd0, decoded}, {24'd0, b});
      // A fresh rising edge and a long high level must both be ignored.
      ready_to_read = 1'b0;
      @(negedge clock);
      ready_to_read = 1'b1;
      bad_hold = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clock);
         if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b1) bad_hold++;
      end
      check("hold_done", bad_hold, 0);
   endtask

   initial begin
      int bad;
      logic [7:0] rb;
      #1;
      computer_ack_reset = 1'b1;
      #1;
      check("reset_state", {29'd0, tx, busy, tx_done}, 32'b100);
      // ready_to_read pulses while reset is held: no frame may follow.
      repeat (2) @(negedge clock);
      ready_to_read = 1'b1;
      repeat (3) @(negedge clock);
      ready_to_read = 1'b0;
      @(negedge clock);
      computer_ack_reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("no_frame_after_reset", bad, 0);

      send_frame(8'hA5, 8'hA5, 1'b1);
      ack_reset();
      send_frame(8'h3C, 8'hFF, 1'b0);
      ack_reset();

      // Abort in the middle of the data bits of an all-zero byte.
      @(negedge clock);
      data_in       = 8'h00;
      ready_to_read = 1'b1;
      @(posedge clock);
      repeat (18) @(posedge clock);
      #2;
      computer_ack_reset = 1'b1;
      #1;
      check("abort_state", {29'd0, tx, busy, tx_done}, 32'b100);
      ready_to_read = 1'b0;
      @(negedge clock);
      @(negedge clock);
      computer_ack_reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
      end
      check("abort_quiet", bad, 0);
      send_frame(8'h81, 8'h00, 1'b0);
      ack_reset();

      send_frame(8'h12, 8'h55, 1'b1);
      ack_reset();
      check("done_low_between", {31'd0, tx_done}, 32'd0);
      send_frame(8'hED, 8'h00, 1'b0);
      ack_reset();
      send_frame(8'h07, 8'h00, 1'b0);
      ack_reset();
      send_frame(8'h03, 8'hFF, 1'b1);
      ack_reset();

      for (int i = 0; i < 10; i++) begin
         rb = 8'($urandom);
         send_frame(rb, 8'($urandom), bit'($urandom % 2));
         ack_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/response_uart_tx.md
Name: response_uart_tx

Overview:
- Reader/transmitter end of the PUF response buffer.
- Waits for the 8-bit response buffer to raise ready_to_read, captures the byte, and serialises it to the host PC as one UART frame: 8N1, LSB first.
- After the stop bit it holds tx_done until the host's computer_ack_reset clears this block together with the buffer, arbiter, scrambler and counter.
- Exactly one frame is sent per challenge/response cycle.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range >= 2.

Ports:
- clock  input  1  system clock, all logic on rising edge
- computer_ack_reset  input  1  reset, asynchronous, active-high; host acknowledge; same net that clears the response buffer
- ready_to_read  input  1  from response buffer; synchronous to clock; high once 8 response bits are stored
- data_in  input  8  response byte from buffer (buffer dataOut); first captured bit is MSB
- tx  output  1  UART serial line to host, idle high
- busy  output  1  high while a frame is in progress (START..STOP)
- tx_done  output  1  high after the frame completes, until reset

Behaviour:
- Reset (async, immediate): tx=1, busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0, rtr_q=0.
- Reset asserted mid-frame aborts the frame immediately; tx returns high with no partial-byte completion.
- Registers and counters:
  - rtr_q: registered copy of ready_to_read; start = ready_to_read & ~rtr_q (rising edge only).
  - Baud counter width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 at the end of each bit (bit_tick).
  - Bit index: 3 bits, 0..7.
- FSM states: IDLE, START, DATA, (PARITY), STOP, DONE.
- IDLE:
  - tx=1, busy=0.
  - On the edge where start=1: capture data_in into the shift register, tx<=0, busy<=1, counter<=0, go to START.
  - tx therefore falls on the first clock edge at which ready_to_read is sampled high.
- START:
  - Hold tx=0 for CLKS_PER_BIT cycles.
  - On bit_tick: tx<=shift[0], bit index<=0, go to DATA.
- DATA:
  - Each bit held CLKS_PER_BIT cycles.
  - On bit_tick, if index<7: shift right, index+1, tx<=next LSB.
  - On bit_tick, if index==7: go to STOP (or PARITY when enabled) with tx<=1 (parity bit when enabled).
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On bit_tick: busy<=0, tx_done<=1, go to DONE.
- DONE:
  - tx=1, tx_done=1.
  - Ignore ready_to_read entirely; exit only via computer_ack_reset.
  - No second frame without a host ack.
- Frame length: 10*CLKS_PER_BIT cycles from tx falling to tx_done rising (11*CLKS_PER_BIT with parity).
- ready_to_read falling or data_in changing mid-frame has no effect; the byte is latched at start.
- ready_to_read held high continuously produces only one frame (edge-triggered).
- busy and tx_done are never both high.

Optional Feature:
- Macro RESP_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx = even parity = XOR of the 8 captured bits, held CLKS_PER_BIT cycles.
  - Frame becomes 8E1, 11*CLKS_PER_BIT cycles.
- Undefined:
  - PARITY state and parity logic absent.
  - Frame is 8N1, 10*CLKS_PER_BIT cycles.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Reset → tx=1, busy=0, tx_done=0; assert reset, raise ready_to_read during reset → no frame after release until a fresh rising edge.
- data_in=8'hA5, pulse ready_to_read rising → tx falls the same sampled edge; line samples at bit centres = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first A5, stop); tx_done rises 40 cycles after tx fell; busy low from then on.
- data_in=8'h3C, ready_to_read held high, change data_in to 8'hFF at cycle 10 → transmitted byte is 3C; after tx_done hold ready_to_read high 100 cycles → no second start bit.
- Assert computer_ack_reset at cycle 18 of a frame with data_in=8'h00 → tx=1 within the same cycle; busy=0, tx_done=0; new rising edge with 8'h81 → full clean frame of 81.
- Back-to-back: frame 8'h12, ack reset, frame 8'hED → both decoded correctly; tx_done low between them.
- RESP_PARITY_EN defined, data_in=8'h07 → parity bit=1, frame 44 cycles; data_in=8'h03 → parity bit=0.
